// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: collects LSB-first bits into a word with a valid/ready output and sticky overrun.
// Optional even-parity frame bit is enabled by defining SHIFT_DESERIALIZER_PARITY_EN.
module shift_deserializer #(
    parameter int WIDTH = 10,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             parity_err
);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] par_out_q, par_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;

    logic             last_bit;
    logic [WIDTH-1:0] word;
    logic             word_perr;

    assign last_bit = ser_valid && (cnt_q == CNT_W'(FL - 1));

`ifdef SHIFT_DESERIALIZER_PARITY_EN
    // The data bits are already in shreg; ser_in on the final edge is the parity bit.
    assign word      = shreg_q;
    assign word_perr = (^shreg_q) ^ ser_in;
`else
    assign word      = {ser_in, shreg_q[WIDTH-1:1]};
    assign word_perr = 1'b0;
`endif

    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        par_out_d = par_out_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        perr_d    = perr_q;
        if (clear) begin
            shreg_d   = '0;
            cnt_d     = '0;
            par_out_d = '0;
            valid_d   = 1'b0;
            ovr_d     = 1'b0;
            perr_d    = 1'b0;
        end else begin
            if (valid_q && par_ready) begin
                valid_d = 1'b0;
            end
            if (ser_valid) begin
                shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
                cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
            end
            // A completed word only replaces par_out if the old one is gone or leaving now.
            if (last_bit) begin
                if (!valid_q || par_ready) begin
                    par_out_d = word;
                    valid_d   = 1'b1;
                    perr_d    = word_perr;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            par_out_q <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            par_out_q <= par_out_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            perr_q    <= perr_d;
        end
    end

    assign par_out    = par_out_q;
    assign par_valid  = valid_q;
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed scenarios plus random traffic against a frame-level model.
module tb_shift_deserializer;
    localparam int WIDTH = 10;
    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = WIDTH + (PAR ? 1 : 0);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic             ser_in = 1'b0;
    logic             ser_valid = 1'b0;
    logic             par_ready = 1'b0;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             overrun;
    logic [CNT_W-1:0] bit_cnt;
    logic             parity_err;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    logic [WIDTH-1:0] seen[$];

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .clear(clear), .ser_in(ser_in), .ser_valid(ser_valid),
        .par_out(par_out), .par_valid(par_valid), .par_ready(par_ready), .overrun(overrun),
        .bit_cnt(bit_cnt), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: bits are placed by arrival index; a frame closes when FL bits are in.
    logic [WIDTH:0]   m_acc = '0;
    int               m_n = 0;
    logic [WIDTH-1:0] m_out = '0;
    logic             m_val = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

    always @(posedge clk or posedge reset) begin
        logic [WIDTH:0] acc;
        int n;
        bit done;
        if (reset || clear) begin
            m_acc <= '0; m_n <= 0; m_out <= '0; m_val <= 1'b0; m_ovr <= 1'b0; m_perr <= 1'b0;
        end else begin
            acc = m_acc; n = m_n; done = 1'b0;
            if (ser_valid) begin
                acc[n] = ser_in;
                n = n + 1;
                if (n == FL) begin
                    done = 1'b1;
                    n = 0;
                end
            end
            if (done) begin
                if (!m_val || par_ready) begin
                    m_out  <= acc[WIDTH-1:0];
                    m_val  <= 1'b1;
                    m_perr <= PAR ? ^acc[FL-1:0] : 1'b0;
                end else begin
                    m_ovr <= 1'b1;
                end
                acc = '0;
            end else if (m_val && par_ready) begin
                m_val <= 1'b0;
            end
            m_acc <= acc;
            m_n   <= n;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("par_out", 32'(par_out), 32'(m_out));
            chk("par_valid", 32'(par_valid), 32'(m_val));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("bit_cnt", 32'(bit_cnt), 32'(m_n));
            chk("parity_err", 32'(parity_err), 32'(m_perr));
            if (par_valid && par_ready) begin
                seen.push_back(par_out);
                $display("xfer word=%h perr=%0d ovr=%0d", par_out, parity_err, overrun);
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic r, input logic c = 1'b0);
        @(negedge clk);
        #1;
        ser_valid = v; ser_in = b; par_ready = r; clear = c;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input int gap, input logic flip,
                              input logic r, input logic r_last);
        for (int i = 0; i < WIDTH; i++) begin
            drive(1'b1, w[i], (i == FL - 1) ? r_last : r);
            if (i < FL - 1) repeat (gap) drive(1'b0, 1'b0, r);
        end
        if (PAR) drive(1'b1, (^w) ^ flip, r_last);
    endtask

    task automatic pulse_clear();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #12 reset = 1'b0;
        chk_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("reset par_out", 32'(par_out), 32'h0);
        chk("reset bit_cnt", 32'(bit_cnt), 32'h0);

        // Word capture, consumer stalled
        for (int i = 0; i < 4; i++) drive(1'b1, 1'(10'h2A5 >> i), 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("cap partial bit_cnt", 32'(bit_cnt), 32'd4);
        pulse_clear();
        send_frame(10'h2A5, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("cap par_out", 32'(par_out), 32'h2A5);
        chk("cap par_valid", 32'(par_valid), 32'h1);
        chk("cap bit_cnt", 32'(bit_cnt), 32'h0);
        chk("cap parity_err", 32'(parity_err), 32'h0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        chk("cap held valid", 32'(par_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("cap consumed", 32'(par_valid), 32'h0);
        chk("cap out kept", 32'(par_out), 32'h2A5);

        // Gapped input
        pulse_clear();
        send_frame(10'h0F3, 2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("gap par_out", 32'(par_out), 32'h0F3);

        // Back-to-back with consumer always ready
        pulse_clear();
        seen.delete();
        send_frame(10'h155, 0, 1'b0, 1'b1, 1'b1);
        send_frame(10'h3FF, 0, 1'b0, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        chk("b2b count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("b2b word0", 32'(seen[0]), 32'h155);
            chk("b2b word1", 32'(seen[1]), 32'h3FF);
        end
        chk("b2b overrun", 32'(overrun), 32'h0);

        // Overrun and sticky behaviour
        pulse_clear();
        send_frame(10'h001, 0, 1'b0, 1'b0, 1'b0);
        send_frame(10'h200, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("ovr par_out", 32'(par_out), 32'h001);
        chk("ovr flag", 32'(overrun), 32'h1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("ovr drained", 32'(par_valid), 32'h0);
        chk("ovr sticky", 32'(overrun), 32'h1);
        pulse_clear();
        chk("ovr cleared", 32'(overrun), 32'h0);
        send_frame(10'h0AA, 0, 1'b0, 1'b0, 1'b0);
        send_frame(10'h055, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("simul par_out", 32'(par_out), 32'h055);
        chk("simul overrun", 32'(overrun), 32'h0);

        // Asynchronous reset mid-word
        pulse_clear();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("areset bit_cnt", 32'(bit_cnt), 32'h0);
        chk("areset valid", 32'(par_valid), 32'h0);
        chk("areset par_out", 32'(par_out), 32'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        send_frame(10'h3C3, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("post-reset word", 32'(par_out), 32'h3C3);

        // clear wins over the final bit of a frame
        pulse_clear();
        for (int i = 0; i < FL - 1; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("clear valid", 32'(par_valid), 32'h0);
        chk("clear bit_cnt", 32'(bit_cnt), 32'h0);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
        pulse_clear();
        send_frame(10'h2A5, 0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("par good word", 32'(par_out), 32'h2A5);
        chk("par good perr", 32'(parity_err), 32'h0);
        send_frame(10'h2A5, 0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("par bad word", 32'(par_out), 32'h2A5);
        chk("par bad perr", 32'(parity_err), 32'h1);
`endif

        // Random traffic
        pulse_clear();
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 99) == 0));
        end
        drive(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
